// File: rtl/gcn_argmax_pkg.sv
// -----------------------------------------------------------------------------
// gcn_argmax_pkg
//
// Shared definitions for the GCN argmax stage:
//   - argmax_state_t : controller states of argmax_sequencer
//   - DEF_*          : default dimensions of the output feature matrix and the
//                      widths of its row/column indices and scores
// -----------------------------------------------------------------------------
package gcn_argmax_pkg;

  // Default geometry of the output feature matrix (nodes x classes).
  localparam int DEF_FEATURE_ROWS = 6;
  localparam int DEF_OUT_COLS     = 3;

  // Default widths: signed score, row index, column/class index.
  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_ROW_W        = 3;
  localparam int DEF_COL_W        = 2;

  // Controller states.
  //   IDLE  : waiting for start
  //   FETCH : issuing one read per column of the current row
  //   LAST  : no read; the final column's data is being captured
  //   WRITE : writing the winning class of the current row
  //   DONE  : one-cycle completion pulse
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LAST  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } argmax_state_t;

endpackage : gcn_argmax_pkg

// File: rtl/argmax_compare_unit.sv
// -----------------------------------------------------------------------------
// argmax_compare_unit
//
// Running-maximum tracker for one row of signed scores. The read request that
// the sequencer issues (strobe + column) is delayed by one cycle so it lines up
// with the memory's read data, which arrives exactly one cycle after the
// strobe. Column 0 always seeds the maximum; later columns replace it only when
// strictly greater, so ties keep the lower class index.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   req_valid  in   read strobe issued this cycle (fm_read_en)
//   req_col    in   column addressed by that read (fm_read_col)
//   rd_data    in   signed score, valid one cycle after req_valid
//   best_idx   out  class index of the running maximum for the current row
// -----------------------------------------------------------------------------
module argmax_compare_unit
  import gcn_argmax_pkg::*;
#(
  parameter int COL_W      = DEF_COL_W,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [COL_W-1:0]      req_col,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [COL_W-1:0]      best_idx
);

  // Request delayed to the cycle in which its data is on rd_data.
  logic                         rd_valid;
  logic [COL_W-1:0]             rd_col;

  // Running maximum, kept signed so the comparison is two's-complement.
  logic signed [DATA_WIDTH-1:0] max_val;
  logic [COL_W-1:0]             max_idx;

  logic signed [DATA_WIDTH-1:0] score;
  assign score = $signed(rd_data);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its inputs regardless of the
  // order in which always_ff blocks are evaluated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_col   <= '0;
    end else begin
      rd_valid <= req_valid;
      rd_col   <= req_col;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (rd_valid) begin
      if (rd_col == '0) begin
        // First column of a row seeds the maximum, discarding the previous row.
        max_val <= score;
        max_idx <= '0;
      end else if (score > max_val) begin
        // Strict greater-than: an equal score keeps the earlier (lower) index.
        max_val <= score;
        max_idx <= rd_col;
      end
    end
  end

  assign best_idx = max_idx;

endmodule : argmax_compare_unit

// File: rtl/argmax_sequencer.sv
// -----------------------------------------------------------------------------
// argmax_sequencer
//
// Final argmax stage of the GCN output. On start it walks the
// FEATURE_ROWS x OUT_COLS matrix of signed scores row by row, issuing one
// single-element read per cycle, tracks the running maximum of each row and
// writes the winning class index of every row to the argmax result store.
//
// Per row: OUT_COLS FETCH cycles (one read each), one LAST cycle in which the
// final column's data is captured, and one WRITE cycle -> OUT_COLS+2 cycles.
// After the last row a single DONE cycle pulses done and returns to IDLE.
//
// All outputs are decoded from registered state only (Moore); start and
// fm_read_data never reach an output combinationally. Address/data outputs are
// forced to 0 whenever their strobe is low.
//
// Ports:
//   clk                 in   system clock, rising edge
//   reset               in   asynchronous, active-high reset
//   start               in   single-cycle request to begin a full pass
//   fm_read_en          out  read strobe to the output feature-map memory
//   fm_read_row         out  row address of the read
//   fm_read_col         out  column address of the read
//   fm_read_data        in   read data, valid exactly 1 cycle after fm_read_en
//   argmax_write_en     out  result write strobe
//   argmax_write_row    out  row being written
//   argmax_write_class  out  winning class index for that row
//   busy                out  pass in progress (FETCH, LAST, WRITE)
//   done                out  one-cycle pulse when the pass completes
// -----------------------------------------------------------------------------
module argmax_sequencer
  import gcn_argmax_pkg::*;
#(
  parameter int FEATURE_ROWS = DEF_FEATURE_ROWS,
  parameter int OUT_COLS     = DEF_OUT_COLS,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ROW_W        = DEF_ROW_W,
  parameter int COL_W        = DEF_COL_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  fm_read_en,
  output logic [ROW_W-1:0]      fm_read_row,
  output logic [COL_W-1:0]      fm_read_col,
  input  logic [DATA_WIDTH-1:0] fm_read_data,
  output logic                  argmax_write_en,
  output logic [ROW_W-1:0]      argmax_write_row,
  output logic [COL_W-1:0]      argmax_write_class,
  output logic                  busy,
  output logic                  done
);

  // Terminal counter values, sized to the counters they are compared with.
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_COLS - 1);

  argmax_state_t    state, state_next;
  logic [ROW_W-1:0] row,   row_next;
  logic [COL_W-1:0] col,   col_next;
  logic [COL_W-1:0] best_idx;

  // ---------------------------------------------------------------------------
  // Running-max datapath. It observes the reads as they are issued and
  // re-aligns them with the returning data internally.
  // ---------------------------------------------------------------------------
  argmax_compare_unit #(
    .COL_W      (COL_W),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_compare (
    .clk       (clk),
    .reset     (reset),
    .req_valid (fm_read_en),
    .req_col   (fm_read_col),
    .rd_data   (fm_read_data),
    .best_idx  (best_idx)
  );

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_next;
      row   <= row_next;
      col   <= col_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and Moore output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_next         = state;
    row_next           = row;
    col_next           = col;
    fm_read_en         = 1'b0;
    fm_read_row        = '0;
    fm_read_col        = '0;
    argmax_write_en    = 1'b0;
    argmax_write_row   = '0;
    argmax_write_class = '0;
    busy               = 1'b0;
    done               = 1'b0;

    case (state)
      IDLE: begin
        // start is only honoured here; every pass begins at element (0,0).
        if (start) begin
          state_next = FETCH;
          row_next   = '0;
          col_next   = '0;
        end
      end

      FETCH: begin
        busy        = 1'b1;
        fm_read_en  = 1'b1;
        fm_read_row = row;
        fm_read_col = col;
        if (col == LAST_COL) begin
          col_next   = '0;
          state_next = LAST;
        end else begin
          col_next = col + 1'b1;
        end
      end

      LAST: begin
        // The final column's data is on fm_read_data now and is folded into
        // the running maximum at the end of this cycle, in time for WRITE.
        busy       = 1'b1;
        state_next = WRITE;
      end

      WRITE: begin
        busy               = 1'b1;
        argmax_write_en    = 1'b1;
        argmax_write_row   = row;
        argmax_write_class = best_idx;
        if (row == LAST_ROW) begin
          state_next = DONE;
        end else begin
          row_next   = row + 1'b1;
          state_next = FETCH;
        end
      end

      DONE: begin
        done       = 1'b1;
        row_next   = '0;
        state_next = IDLE;
      end

      default: begin
        // Unreachable encodings recover to a clean idle.
        state_next = IDLE;
        row_next   = '0;
        col_next   = '0;
      end
    endcase
  end

endmodule : argmax_sequencer

// File: tb/tb_argmax_sequencer.sv
// -----------------------------------------------------------------------------
// tb_argmax_sequencer
//
// Directed bench for argmax_sequencer with default parameters. A small
// feature-map memory model returns data one cycle after each read strobe and
// drives a junk pattern otherwise. Cycle numbers are counted from the edge that
// samples start: cycle 1 is the first cycle after that edge. Outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_argmax_sequencer;

  localparam int FR   = 6;
  localparam int OC   = 3;
  localparam int DW   = 16;
  localparam int RW   = 3;
  localparam int CW   = 2;
  localparam int VW   = 1 + RW + CW + 1 + RW + CW + 1 + 1;
  localparam int ROWC = OC + 2;          // cycles per row
  localparam int DONE_CYC = ROWC * FR + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          fm_read_en;
  logic [RW-1:0] fm_read_row;
  logic [CW-1:0] fm_read_col;
  logic [DW-1:0] fm_read_data;
  logic          argmax_write_en;
  logic [RW-1:0] argmax_write_row;
  logic [CW-1:0] argmax_write_class;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [FR][OC];
  int            exp_class [FR];

  always #5 clk = ~clk;

  argmax_sequencer #(
    .FEATURE_ROWS (FR),
    .OUT_COLS     (OC),
    .DATA_WIDTH   (DW),
    .ROW_W        (RW),
    .COL_W        (CW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .fm_read_en         (fm_read_en),
    .fm_read_row        (fm_read_row),
    .fm_read_col        (fm_read_col),
    .fm_read_data       (fm_read_data),
    .argmax_write_en    (argmax_write_en),
    .argmax_write_row   (argmax_write_row),
    .argmax_write_class (argmax_write_class),
    .busy               (busy),
    .done               (done)
  );

  // Feature-map memory: data valid exactly one cycle after the strobe,
  // a recognisable junk value otherwise.
  always @(posedge clk) begin
    if (fm_read_en && int'(fm_read_row) < FR && int'(fm_read_col) < OC)
      fm_read_data <= mem[int'(fm_read_row)][int'(fm_read_col)];
    else
      fm_read_data <= 16'hDEAD;
  end

  // Packed view of every DUT output.
  function automatic logic [VW-1:0] observed();
    return {fm_read_en, fm_read_row, fm_read_col, argmax_write_en,
            argmax_write_row, argmax_write_class, busy, done};
  endfunction

  // Expected outputs in cycle c of a pass whose start was sampled at cycle 0.
  function automatic logic [VW-1:0] model(int c);
    logic          re, we, bz, dn;
    logic [RW-1:0] rr, wr;
    logic [CW-1:0] rc, wc;
    int            r, p;
    re = 1'b0; we = 1'b0; bz = 1'b0; dn = 1'b0;
    rr = '0;   wr = '0;   rc = '0;   wc = '0;
    if (c >= 1 && c <= ROWC * FR) begin
      r  = (c - 1) / ROWC;
      p  = (c - 1) % ROWC;
      bz = 1'b1;
      if (p < OC) begin
        re = 1'b1;
        rr = RW'(r);
        rc = CW'(p);
      end else if (p == OC + 1) begin
        we = 1'b1;
        wr = RW'(r);
        wc = CW'(exp_class[r]);
      end
    end else if (c == DONE_CYC) begin
      dn = 1'b1;
    end
    return {re, rr, rc, we, wr, wc, bz, dn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds start for one sampling edge; returns in cycle 1 of the pass.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    #3;
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", observed());
    end
    step();
    step();
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL reset_held: got %h expected 0", observed());
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (observed() !== '0) begin
        errors++;
        $display("FAIL idle_after_reset[%0d]: got %h expected 0", i, observed());
      end
    end
  endtask

  // Covers the class results of every row, write/done timing, busy window and
  // the per-row read pattern.
  task automatic test_full_pass();
    int n_wr, n_done;
    n_wr = 0; n_done = 0;
    pulse_start();
    for (int c = 1; c <= DONE_CYC + 4; c++) begin
      checks++;
      if (observed() !== model(c)) begin
        errors++;
        $display("FAIL full_pass cycle %0d: got %h expected %h", c, observed(), model(c));
      end
      if (argmax_write_en) n_wr++;
      if (done) n_done++;
      step();
    end
    checks++;
    if (n_wr != FR) begin
      errors++;
      $display("FAIL full_pass_write_count: got %0d expected %0d", n_wr, FR);
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL full_pass_done_count: got %0d expected 1", n_done);
    end
  endtask

  // start during FETCH (cycle 2) and DONE (cycle 31) is ignored; start in
  // IDLE at cycle 33 launches a new pass whose first write lands at 38.
  task automatic test_ignored_start();
    int            n_wr;
    logic [VW-1:0] exp;
    n_wr = 0;
    pulse_start();
    for (int c = 1; c <= 33 + DONE_CYC + 1; c++) begin
      start = 1'b0;
      exp   = (c >= 34) ? model(c - 33) : model(c);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL ignored_start cycle %0d: got %h expected %h", c, observed(), exp);
      end
      if (argmax_write_en) n_wr++;
      start = (c == 2 || c == DONE_CYC || c == 33);
      step();
    end
    start = 1'b0;
    checks++;
    if (n_wr != 2 * FR) begin
      errors++;
      $display("FAIL ignored_start_write_count: got %0d expected %0d", n_wr, 2 * FR);
    end
  endtask

  // Reset asserted mid-cycle during row 3 FETCH aborts the pass.
  task automatic test_reset_mid_pass();
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (observed() !== model(c)) begin
        errors++;
        $display("FAIL pre_abort cycle %0d: got %h expected %h", c, observed(), model(c));
      end
      if (c < 16) step();
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL async_abort: got %h expected 0", observed());
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (observed() !== '0) begin
        errors++;
        $display("FAIL idle_after_abort[%0d]: got %h expected 0", i, observed());
      end
      step();
    end
    pulse_start();
    for (int c = 1; c <= DONE_CYC + 2; c++) begin
      checks++;
      if (observed() !== model(c)) begin
        errors++;
        $display("FAIL restart_pass cycle %0d: got %h expected %h", c, observed(), model(c));
      end
      step();
    end
  endtask

  initial begin
    mem[0] = '{16'd5,    16'd9,    16'd2};
    mem[1] = '{16'd7,    16'd7,    16'd3};
    mem[2] = '{16'd4,    16'd8,    16'd8};
    mem[3] = '{16'hFFFC, 16'hFFFF, 16'hFFF8};
    mem[4] = '{16'h8000, 16'h8000, 16'h8001};
    mem[5] = '{16'd3,    16'hFFFE, 16'd3};
    exp_class = '{1, 0, 1, 1, 2, 0};
    reset = 1'b1;
    start = 1'b0;

    test_reset();
    test_full_pass();
    test_ignored_start();
    test_reset_mid_pass();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule : tb_argmax_sequencer
